rp_sd_arbiter: RTL
==================

# rp_sd_arbiter

Round-robin arbiter that sits between the eight RPxx drive units and the shared SD controller in the RP disk subsystem. It collects per-drive SD access requests, grants the SD controller to one drive at a time, and latches that drive's operation and linear sector address for the transfer. It drives the current-drive select used by the data path, and it acknowledges the owning drive when the SD transfer completes. A watchdog releases the grant if the SD controller never completes.

## Interface
Parameters:
- TIMEOUT, 24'd10_000_000, clock cycles allowed in WAIT before forced release; legal range 2..2^24-1.

Ports:
- clk  in  1  system clock. One clock domain.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear (massbus INIT), active-high.
- rpSDREQ  in  8  per-drive request, level; bit i = drive i.
- rpSDOP  in  24  per-drive SD operation; drive i at [3i+2:3i].
- rpSDLSA  in  168  per-drive linear sector address; drive i at [21i+20:21i].
- sdDONE  in  1  one-cycle pulse from the SD controller; transfer complete.
- rpSDACK  out  8  one-hot, one-cycle acknowledge to the owning drive.
- sdSTART  out  1  one-cycle pulse that starts the SD controller.
- sdOP  out  3  latched operation of the granted drive.
- sdLSA  out  21  latched sector address of the granted drive.
- sdSCAN  out  3  index of the granted or last-granted drive.
- arbBUSY  out  1  high in every state except IDLE.
- arbTIMEOUT  out  1  sticky watchdog flag.

## Operation
- States: IDLE, START, WAIT, ACK, GAP. The state is encoded in registers, and every output is registered.
- Priority pointer `last` (3 bits) holds the index of the most recent grant. Search order is last+1, last+2, …, last+8, all mod 8. The first drive in that order with rpSDREQ set wins.
- IDLE: if rpSDREQ is nonzero, latch the winner into sdSCAN and `last`, latch its rpSDOP slice into sdOP and its rpSDLSA slice into sdLSA, then go to START. Otherwise stay in IDLE.
- START: sdSTART=1 for this cycle only. Clear the watchdog counter. Go to WAIT.
- WAIT: if sdDONE, go to ACK. Otherwise increment the counter. When the counter equals TIMEOUT-1, set arbTIMEOUT and go to ACK.
- A drive that drops rpSDREQ during WAIT does not abort the operation. sdOP, sdLSA and sdSCAN stay stable from the IDLE grant until the next grant.
- ACK: rpSDACK[sdSCAN]=1 for this cycle only. Go to GAP.
- GAP: ignore all requests for one cycle so the acknowledged drive can drop rpSDREQ. Go to IDLE.
- sdDONE received outside WAIT is ignored.
- clr (synchronous, highest priority after rst): go to IDLE, set last=7, clear arbTIMEOUT, sdSTART and rpSDACK. sdOP, sdLSA and sdSCAN keep their values.
- Reset values: state=IDLE, last=7, sdSCAN=0, sdOP=0, sdLSA=0, sdSTART=0, rpSDACK=0, arbBUSY=0, arbTIMEOUT=0, counter=0. Because last resets to 7, drive 0 has first priority after reset.
- Watchdog counter is 24 bits and saturates. It does not wrap while in WAIT.

## Timing
- Request seen in IDLE at cycle k: sdSCAN, sdOP and sdLSA are valid and arbBUSY=1 from cycle k+1. sdSTART is high during cycle k+1.
- sdDONE in cycle m: rpSDACK high in cycle m+1, GAP in cycle m+2, IDLE in cycle m+3. The earliest next grant is visible at cycle m+4.
- Fastest round trip: sdDONE in the first WAIT cycle (k+2) gives ACK at k+3.
- Timeout: with sdSTART in cycle s, the counter reaches TIMEOUT-1 in cycle s+TIMEOUT. arbTIMEOUT and ACK both occur in cycle s+TIMEOUT+1.
- sdDONE and the timeout condition in the same cycle: sdDONE wins and arbTIMEOUT is not set.
- clr in any cycle: the next cycle is IDLE with all strobes low. No ACK is issued for the cancelled operation.
- rst is asserted asynchronously. Release is expected to be synchronised externally; the block adds no synchroniser.

## Test plan
- Single request: drive 3 requests with op=3'd2, LSA=21'h012345. Expect sdSCAN=3, sdOP=2, sdLSA=012345, and an sdSTART pulse 1 cycle later. With sdDONE 10 cycles later, expect rpSDACK=8'h08 on the following cycle.
- Round-robin: after reset, drives 0, 2 and 5 request continuously and each done comes after 4 cycles. Expect grant order 0, 2, 5, 0, 2, 5. Expect exactly one ACK per grant and the gap between sdDONE and the next sdSTART to be 4 cycles.
- All eight requesting: after drive 6 is granted, the next eight grants are 7, 0, 1, 2, 3, 4, 5, 6.
- Watchdog: with TIMEOUT=16, drive 1 requests and sdDONE is never given. Expect arbTIMEOUT=1 and rpSDACK=8'h02 17 cycles after sdSTART. arbTIMEOUT stays set until clr.
- clr mid-WAIT: drive 4 is granted and clr is pulsed in WAIT. Next cycle expect IDLE, arbBUSY=0 and no rpSDACK pulse. A late sdDONE is ignored. With drives 0 and 4 requesting afterwards, drive 0 is granted first.
- Async reset mid-transfer: drop rst in WAIT between clock edges. All outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rp_sd_arbiter.sv
// Round-robin arbiter granting the shared SD controller to one of eight RP drives.
// Latches the winner's operation/address, pulses start, acks on completion, with a watchdog.
module rp_sd_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [7:0]   rpSDREQ,
  input  logic [23:0]  rpSDOP,
  input  logic [167:0] rpSDLSA,
  input  logic         sdDONE,
  output logic [7:0]   rpSDACK,
  output logic         sdSTART,
  output logic [2:0]   sdOP,
  output logic [20:0]  sdLSA,
  output logic [2:0]   sdSCAN,
  output logic         arbBUSY,
  output logic         arbTIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK,
    S_GAP
  } state_t;

  localparam logic [23:0] TMO_LAST = TIMEOUT - 24'd1;
  localparam logic [23:0] CNT_MAX  = 24'hFF_FFFF;

  state_t       r_state;
  logic [2:0]   r_last;
  logic [2:0]   r_scan;
  logic [2:0]   r_op;
  logic [20:0]  r_lsa;
  logic         r_start;
  logic [7:0]   r_ack;
  logic         r_busy;
  logic         r_timeout;
  logic [23:0]  r_count;

  state_t       w_state_next;
  logic [2:0]   w_last_next;
  logic [2:0]   w_scan_next;
  logic [2:0]   w_op_next;
  logic [20:0]  w_lsa_next;
  logic         w_start_next;
  logic [7:0]   w_ack_next;
  logic         w_busy_next;
  logic         w_timeout_next;
  logic [23:0]  w_count_next;

  logic [2:0]   w_op_arr  [8];
  logic [20:0]  w_lsa_arr [8];
  logic [7:0]   w_rot_req;
  logic [2:0]   w_win_ofs;
  logic [2:0]   w_winner;

  // Bit gi of w_rot_req is the drive gi+1 places after the last grant (mod 8).
  for (genvar gi = 0; gi < 8; gi++) begin : g_drive
    localparam logic [2:0] OFS = 3'(gi + 1);
    assign w_op_arr[gi]  = rpSDOP[3*gi +: 3];
    assign w_lsa_arr[gi] = rpSDLSA[21*gi +: 21];
    assign w_rot_req[gi] = rpSDREQ[r_last + OFS];
  end

  always_comb begin
    w_win_ofs = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot_req[i]) begin
        w_win_ofs = 3'(i);
      end
    end
  end

  assign w_winner = r_last + w_win_ofs + 3'd1;

  always_comb begin
    w_state_next   = r_state;
    w_last_next    = r_last;
    w_scan_next    = r_scan;
    w_op_next      = r_op;
    w_lsa_next     = r_lsa;
    w_start_next   = 1'b0;
    w_ack_next     = 8'd0;
    w_timeout_next = r_timeout;
    w_count_next   = r_count;

    case (r_state)
      S_IDLE: begin
        if (|rpSDREQ) begin
          w_state_next = S_START;
          w_last_next  = w_winner;
          w_scan_next  = w_winner;
          w_op_next    = w_op_arr[w_winner];
          w_lsa_next   = w_lsa_arr[w_winner];
          w_start_next = 1'b1;
        end
      end
      S_START: begin
        w_count_next = 24'd0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes precedence over a watchdog expiry in the same cycle.
        if (sdDONE) begin
          w_state_next = S_ACK;
          w_ack_next   = 8'd1 << r_scan;
        end else if (r_count == TMO_LAST) begin
          w_state_next   = S_ACK;
          w_ack_next     = 8'd1 << r_scan;
          w_timeout_next = 1'b1;
        end else if (r_count != CNT_MAX) begin
          w_count_next = r_count + 24'd1;
        end
      end
      S_ACK: begin
        w_state_next = S_GAP;
      end
      S_GAP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_busy_next = (w_state_next != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_last    <= 3'd7;
      r_scan    <= 3'd0;
      r_op      <= 3'd0;
      r_lsa     <= 21'd0;
      r_start   <= 1'b0;
      r_ack     <= 8'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= 24'd0;
    end else if (clr) begin
      // The latched operation, address and scan index survive a massbus INIT.
      r_state   <= S_IDLE;
      r_last    <= 3'd7;
      r_start   <= 1'b0;
      r_ack     <= 8'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= 24'd0;
    end else begin
      r_state   <= w_state_next;
      r_last    <= w_last_next;
      r_scan    <= w_scan_next;
      r_op      <= w_op_next;
      r_lsa     <= w_lsa_next;
      r_start   <= w_start_next;
      r_ack     <= w_ack_next;
      r_busy    <= w_busy_next;
      r_timeout <= w_timeout_next;
      r_count   <= w_count_next;
    end
  end

  assign rpSDACK    = r_ack;
  assign sdSTART    = r_start;
  assign sdOP       = r_op;
  assign sdLSA      = r_lsa;
  assign sdSCAN     = r_scan;
  assign arbBUSY    = r_busy;
  assign arbTIMEOUT = r_timeout;

endmodule
